fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
- Parametrised next-generation operand forwarding and hazard unit for the pipelined core.
- Serves any number of source operands against any number of forwarding stages, plus a completion bus for long-latency writes.
- Keeps a registered busy scoreboard of pending long-latency destinations.
- Drives the pipeline stall and a stall-watchdog state machine.
- Sits beside the ID/EXE boundary; its selects steer the EXE operand muxes.

Parameters:
REG_ADDR_W, 4, register address width; scoreboard depth is 2**REG_ADDR_W
NUM_SRC, 3, number of source operands checked per cycle
NUM_STAGES, 2, forwarding stages; index 0 is the youngest (EXE/MEM), higher is older
SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_STAGES+2
STALL_TIMEOUT, 255, consecutive stall cycles before watchdog trips (8-bit counter)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
en  in  1  1 = forwarding enabled; 0 = any in-flight match stalls instead of forwarding
flush  in  1  kill current issue (issue_valid ignored this cycle)
src_valid  in  NUM_SRC  source i is actually read
src_addr  in  NUM_SRC*REG_ADDR_W  source addresses, src i at [i*REG_ADDR_W +: REG_ADDR_W]
stage_wb_en  in  NUM_STAGES  stage k will write back
stage_dest  in  NUM_STAGES*REG_ADDR_W  stage k destination
stage_rdy  in  NUM_STAGES  stage k result already available (0 e.g. load in MEM)
issue_valid  in  1  instruction leaving ID this cycle
issue_long  in  1  issuing instruction is long-latency
issue_dest  in  REG_ADDR_W  its destination
cmpl_valid  in  1  long-latency result on completion bus
cmpl_dest  in  REG_ADDR_W  completion destination
fwd_sel  out  NUM_SRC*SEL_W  per source: 0 register file, k+1 stage k, NUM_STAGES+1 completion bus
hazard_stall  out  1  stall ID and freeze issue
busy_vec  out  2**REG_ADDR_W  registered scoreboard
stall_timeout  out  1  sticky watchdog flag
fwd_count  out  16  forwards taken (statistics)
stall_count  out  16  stall cycles (statistics)

Behaviour:
- Per source i, combinational, only when src_valid[i]:
  - Scan stages 0..NUM_STAGES-1; the first k with stage_wb_en[k] and stage_dest[k]==src matches; the youngest match wins.
  - en=1 and stage_rdy[k]=1: sel = k+1.
  - en=1 and stage_rdy[k]=0: stall.
  - en=0 and any match: stall, sel = 0.
  - No stage match but busy_vec[src]=1:
    - cmpl_valid and cmpl_dest==src and en=1: sel = NUM_STAGES+1, no stall.
    - Otherwise: stall.
  - src_valid[i]=0: sel = 0, no contribution to stall.
- hazard_stall = OR of per-source stall terms. Whenever hazard_stall=1, all fwd_sel are 0.
- Scoreboard, on clk:
  - Clear bit cmpl_dest when cmpl_valid.
  - Set bit issue_dest when issue_valid && issue_long && !hazard_stall && !flush.
  - Set and clear of the same register in one cycle: set wins.
  - flush does not clear already-set bits.
- Watchdog FSM:
  - RUN -> STALL when hazard_stall.
  - STALL -> RUN when !hazard_stall; the counter clears.
  - STALL counts consecutive stall cycles, saturating at 8 bits; when count==STALL_TIMEOUT go to TRIP.
  - TRIP: stall_timeout=1, held until reset; forwarding and stall logic continue unaffected.
- Reset: busy_vec=0, FSM=RUN, counter=0, stall_timeout=0, fwd_count=0, stall_count=0. Combinational outputs follow the inputs with busy_vec=0.
- Reset asserted mid-stall aborts the count immediately.
- Latency: fwd_sel and hazard_stall are zero-cycle. A scoreboard update is visible the cycle after the edge.

Optional Feature:
FWD_STATS_EN
- Defined:
  - fwd_count increments each cycle at least one fwd_sel is nonzero.
  - stall_count increments each cycle hazard_stall=1.
  - Both are 16-bit, saturating at 16'hFFFF, and reset to 0.
- Undefined: both outputs tied to 0 and no counter flops are built.

Test Plan:
- en=1, src0=5, stage0 wb_en=1 dest=5 rdy=1, stage1 dest=5 -> fwd_sel[src0]=1 (youngest wins), hazard_stall=0.
- en=1, src1=3, stage0 dest=3 rdy=0 -> hazard_stall=1, all sel 0; next cycle drop stage0 and give stage1 dest=3 rdy=1 -> sel=2, stall=0.
- Issue long to r7, then read r7 -> stall; cmpl_valid dest=7 in the same cycle as the read -> sel=3, stall=0; next cycle busy_vec[7]=0.
- Same-cycle issue_long dest=4 and cmpl dest=4 with busy set -> busy_vec[4]=1 after the edge; issue with flush=1 -> no bit set.
- en=0, src2=9, stage1 dest=9 rdy=1 -> stall=1, sel=0.
- Hold stall for 255 cycles -> stall_timeout=1 and stays 1 after the stall releases; drive rst low -> 0 asynchronously.
- With FWD_STATS_EN: 3 forward cycles + 2 stall cycles -> fwd_count=3, stall_count=2.

Source files
------------

// File: rtl/fwd_scoreboard_unit.sv
// Operand forwarding and hazard unit with a long-latency busy scoreboard,
// a stall watchdog, and optional forward/stall statistics counters.
// Optional feature macro: FWD_STATS_EN (builds the fwd_count/stall_count
// counters; when undefined both outputs are tied to zero).
module fwd_scoreboard_unit #(
    parameter int REG_ADDR_W    = 4,
    parameter int NUM_SRC       = 3,
    parameter int NUM_STAGES    = 2,
    parameter int SEL_W         = 2,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           flush,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0]  src_addr,
    input  logic [NUM_STAGES-1:0]          stage_wb_en,
    input  logic [NUM_STAGES*REG_ADDR_W-1:0] stage_dest,
    input  logic [NUM_STAGES-1:0]          stage_rdy,
    input  logic                           issue_valid,
    input  logic                           issue_long,
    input  logic [REG_ADDR_W-1:0]          issue_dest,
    input  logic                           cmpl_valid,
    input  logic [REG_ADDR_W-1:0]          cmpl_dest,
    output logic [NUM_SRC*SEL_W-1:0]       fwd_sel,
    output logic                           hazard_stall,
    output logic [2**REG_ADDR_W-1:0]       busy_vec,
    output logic                           stall_timeout,
    output logic [15:0]                    fwd_count,
    output logic [15:0]                    stall_count
);

    localparam logic [7:0] TIMEOUT8 = 8'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        WD_RUN,
        WD_STALL,
        WD_TRIP
    } wd_state_t;

    logic [NUM_SRC*SEL_W-1:0] sel_raw;
    logic                     stall_any;
    logic [2**REG_ADDR_W-1:0] busy_nxt;
    wd_state_t                wd_state, wd_nxt;
    logic [7:0]               stall_cnt, stall_cnt_nxt;

    // Per-source hazard resolution: youngest stage match first, then the scoreboard/completion bus.
    always_comb begin : operand_check
        logic                  matched;
        logic [REG_ADDR_W-1:0] addr;
        sel_raw   = '0;
        stall_any = 1'b0;
        matched   = 1'b0;
        addr      = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            addr    = src_addr[i*REG_ADDR_W +: REG_ADDR_W];
            matched = 1'b0;
            if (src_valid[i]) begin
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (!matched && stage_wb_en[k] &&
                        stage_dest[k*REG_ADDR_W +: REG_ADDR_W] == addr) begin
                        matched = 1'b1;
                        if (en && stage_rdy[k])
                            sel_raw[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
                        else
                            stall_any = 1'b1;
                    end
                end
                if (!matched && busy_vec[addr]) begin
                    if (en && cmpl_valid && cmpl_dest == addr)
                        sel_raw[i*SEL_W +: SEL_W] = SEL_W'(NUM_STAGES + 1);
                    else
                        stall_any = 1'b1;
                end
            end
        end
    end

    assign hazard_stall  = stall_any;
    assign fwd_sel       = stall_any ? '0 : sel_raw;
    assign stall_timeout = (wd_state == WD_TRIP);

    // Scoreboard next value: completion clears first so a same-register issue set wins.
    always_comb begin
        busy_nxt = busy_vec;
        if (cmpl_valid)
            busy_nxt[cmpl_dest] = 1'b0;
        if (issue_valid && issue_long && !stall_any && !flush)
            busy_nxt[issue_dest] = 1'b1;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_vec <= '0;
        else
            busy_vec <= busy_nxt;
    end

    // Watchdog state and consecutive-stall counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_state  <= WD_RUN;
            stall_cnt <= '0;
        end else begin
            wd_state  <= wd_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    // Watchdog next state: the first stall cycle counts as one; trips when the count hits the timeout.
    always_comb begin
        wd_nxt        = wd_state;
        stall_cnt_nxt = stall_cnt;
        case (wd_state)
            WD_RUN: begin
                if (stall_any) begin
                    stall_cnt_nxt = 8'd1;
                    wd_nxt        = (TIMEOUT8 == 8'd1) ? WD_TRIP : WD_STALL;
                end
            end
            WD_STALL: begin
                if (!stall_any) begin
                    wd_nxt        = WD_RUN;
                    stall_cnt_nxt = '0;
                end else begin
                    stall_cnt_nxt = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
                    if (stall_cnt_nxt == TIMEOUT8)
                        wd_nxt = WD_TRIP;
                end
            end
            WD_TRIP: begin
                wd_nxt = WD_TRIP;
            end
            default: begin
                wd_nxt        = WD_RUN;
                stall_cnt_nxt = '0;
            end
        endcase
    end

`ifdef FWD_STATS_EN
    // Saturating statistics: cycles with any forward taken, and cycles stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fwd_count   <= '0;
            stall_count <= '0;
        end else begin
            if ((|fwd_sel) && fwd_count != 16'hFFFF)
                fwd_count <= fwd_count + 16'd1;
            if (stall_any && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
`else
    assign fwd_count   = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Self-checking bench for fwd_scoreboard_unit: expected combinational results
// are queued as stimulus is driven and popped when the outputs are sampled.
module tb_fwd_scoreboard_unit;

    localparam int RW  = 4;
    localparam int NS  = 3;
    localparam int NST = 2;
    localparam int SW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en, flush;
    logic [NS-1:0]     src_valid;
    logic [NS*RW-1:0]  src_addr;
    logic [NST-1:0]    stage_wb_en;
    logic [NST*RW-1:0] stage_dest;
    logic [NST-1:0]    stage_rdy;
    logic              issue_valid, issue_long;
    logic [RW-1:0]     issue_dest;
    logic              cmpl_valid;
    logic [RW-1:0]     cmpl_dest;
    logic [NS*SW-1:0]  fwd_sel;
    logic              hazard_stall;
    logic [15:0]       busy_vec;
    logic              stall_timeout;
    logic [15:0]       fwd_count, stall_count;

    always #5 clk = ~clk;

    fwd_scoreboard_unit #(
        .REG_ADDR_W(RW), .NUM_SRC(NS), .NUM_STAGES(NST), .SEL_W(SW), .STALL_TIMEOUT(255)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush),
        .src_valid(src_valid), .src_addr(src_addr),
        .stage_wb_en(stage_wb_en), .stage_dest(stage_dest), .stage_rdy(stage_rdy),
        .issue_valid(issue_valid), .issue_long(issue_long), .issue_dest(issue_dest),
        .cmpl_valid(cmpl_valid), .cmpl_dest(cmpl_dest),
        .fwd_sel(fwd_sel), .hazard_stall(hazard_stall), .busy_vec(busy_vec),
        .stall_timeout(stall_timeout), .fwd_count(fwd_count), .stall_count(stall_count)
    );

    typedef struct {
        string            tag;
        logic [NS*SW-1:0] sel;
        logic             stall;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; flush = 1'b0;
        src_valid = '0; src_addr = '0;
        stage_wb_en = '0; stage_dest = '0; stage_rdy = '0;
        issue_valid = 1'b0; issue_long = 1'b0; issue_dest = '0;
        cmpl_valid = 1'b0; cmpl_dest = '0;
    endtask

    task automatic set_src(input int i, input logic [RW-1:0] a);
        src_valid[i] = 1'b1;
        src_addr[i*RW +: RW] = a;
    endtask

    task automatic set_stage(input int k, input logic [RW-1:0] a, input logic rdy);
        stage_wb_en[k] = 1'b1;
        stage_dest[k*RW +: RW] = a;
        stage_rdy[k] = rdy;
    endtask

    task automatic issue(input logic [RW-1:0] d, input logic lng);
        issue_valid = 1'b1; issue_long = lng; issue_dest = d;
    endtask

    task automatic complete(input logic [RW-1:0] d);
        cmpl_valid = 1'b1; cmpl_dest = d;
    endtask

    task automatic push_exp(input string tag, input logic [NS*SW-1:0] sel, input logic stall);
        exp_t e;
        e.tag = tag; e.sel = sel; e.stall = stall;
        exp_q.push_back(e);
    endtask

    // Sample on the falling edge, away from the active edge.
    task automatic compare_comb();
        exp_t e;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val({e.tag, "_sel"}, 32'(fwd_sel), 32'(e.sel));
            check_val({e.tag, "_stall"}, 32'(hazard_stall), 32'(e.stall));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hold_stall_inputs();
        idle_inputs();
        en = 1'b0;
        set_src(2, 4'd9);
        set_stage(1, 4'd9, 1'b1);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b0;
        #12;
        check_val("rst_busy", 32'(busy_vec), 32'h0);
        check_val("rst_timeout", 32'(stall_timeout), 32'h0);
        check_val("rst_fwd_count", 32'(fwd_count), 32'h0);
        check_val("rst_stall_count", 32'(stall_count), 32'h0);
        push_exp("rst_comb", '0, 1'b0);
        compare_comb();
        rst = 1'b1;
        tick();

        // Youngest stage wins.
        idle_inputs(); set_src(0, 4'd5); set_stage(0, 4'd5, 1'b1); set_stage(1, 4'd5, 1'b1);
        push_exp("youngest", 6'b000001, 1'b0); compare_comb(); tick();
        // Only the older stage matches.
        idle_inputs(); set_src(0, 4'd5); set_stage(1, 4'd5, 1'b1);
        push_exp("older", 6'b000010, 1'b0); compare_comb(); tick();
        // Not-ready youngest stage stalls and zeroes every select.
        idle_inputs(); set_src(1, 4'd3); set_src(0, 4'd5);
        set_stage(0, 4'd3, 1'b0); set_stage(1, 4'd5, 1'b1);
        push_exp("not_ready", 6'b000000, 1'b1); compare_comb(); tick();
        idle_inputs(); set_src(1, 4'd3); set_stage(1, 4'd3, 1'b1);
        push_exp("src1_stage1", 6'b001000, 1'b0); compare_comb(); tick();
        // Unread sources contribute nothing.
        idle_inputs(); src_addr[0 +: RW] = 4'd6; set_stage(0, 4'd6, 1'b0);
        push_exp("src_invalid", 6'b000000, 1'b0); compare_comb(); tick();
        // Three sources forwarded at once.
        idle_inputs(); set_src(0, 4'd1); set_src(1, 4'd2); set_src(2, 4'd1);
        set_stage(0, 4'd1, 1'b1); set_stage(1, 4'd2, 1'b1);
        push_exp("multi_src", 6'b011001, 1'b0); compare_comb(); tick();

        // Long-latency issue to r7, stalled read, completion-bus forward.
        idle_inputs(); issue(4'd7, 1'b1);
        push_exp("issue_r7", '0, 1'b0); compare_comb(); tick();
        check_val("busy_r7_set", 32'(busy_vec), 32'h0080);
        idle_inputs(); set_src(0, 4'd7);
        push_exp("read_busy", '0, 1'b1); compare_comb(); tick();
        check_val("busy_r7_hold", 32'(busy_vec), 32'h0080);
        idle_inputs(); set_src(0, 4'd7); complete(4'd7);
        push_exp("cmpl_fwd", 6'b000011, 1'b0); compare_comb(); tick();
        check_val("busy_r7_clear", 32'(busy_vec), 32'h0000);

        // Set-vs-clear priority, flush, and stall blocking the issue.
        idle_inputs(); issue(4'd4, 1'b1); tick();
        check_val("busy_r4_set", 32'(busy_vec), 32'h0010);
        idle_inputs(); issue(4'd4, 1'b1); complete(4'd4); tick();
        check_val("set_wins", 32'(busy_vec), 32'h0010);
        idle_inputs(); complete(4'd4); tick();
        check_val("cmpl_clear", 32'(busy_vec), 32'h0000);
        idle_inputs(); issue(4'd4, 1'b1); flush = 1'b1; tick();
        check_val("flush_blocks_set", 32'(busy_vec), 32'h0000);
        idle_inputs(); issue(4'd5, 1'b0); tick();
        check_val("short_no_set", 32'(busy_vec), 32'h0000);
        idle_inputs(); issue(4'd2, 1'b1); tick();
        idle_inputs(); flush = 1'b1; tick();
        check_val("flush_keeps_bits", 32'(busy_vec), 32'h0004);
        idle_inputs(); set_src(0, 4'd2); issue(4'd6, 1'b1);
        push_exp("stall_blocks_issue", '0, 1'b1); compare_comb(); tick();
        check_val("stall_no_set", 32'(busy_vec), 32'h0004);
        idle_inputs(); en = 1'b0; set_src(0, 4'd2); complete(4'd2);
        push_exp("en0_cmpl_stall", '0, 1'b1); compare_comb(); tick();
        check_val("en0_cmpl_clears", 32'(busy_vec), 32'h0000);

        // Forwarding disabled: any match stalls.
        hold_stall_inputs();
        push_exp("en0_match", '0, 1'b1); compare_comb(); tick();

        // Watchdog: a released stall restarts the count.
        idle_inputs(); tick();
        hold_stall_inputs();
        repeat (200) tick();
        idle_inputs(); tick();
        hold_stall_inputs();
        repeat (254) tick();
        check_val("wd_254", 32'(stall_timeout), 32'h0);
        tick();
        check_val("wd_255", 32'(stall_timeout), 32'h1);
        idle_inputs(); set_src(0, 4'd8); set_stage(0, 4'd8, 1'b1);
        push_exp("trip_fwd", 6'b000001, 1'b0); compare_comb(); tick();
        check_val("wd_sticky", 32'(stall_timeout), 32'h1);
        #2 rst = 1'b0;
        #1 check_val("wd_async_rst", 32'(stall_timeout), 32'h0);
        #2 rst = 1'b1;
        tick();

        // Reset mid-stall aborts the count.
        hold_stall_inputs();
        repeat (100) tick();
        rst = 1'b0;
        #3 rst = 1'b1;
        repeat (254) tick();
        check_val("wd_rst_abort_254", 32'(stall_timeout), 32'h0);
        tick();
        check_val("wd_rst_abort_255", 32'(stall_timeout), 32'h1);

        // Statistics from a clean reset: 3 forward cycles, 2 stall cycles.
        idle_inputs();
        rst = 1'b0;
        #3 rst = 1'b1;
        tick();
        set_src(0, 4'd5); set_stage(0, 4'd5, 1'b1);
        repeat (3) tick();
        stage_rdy[0] = 1'b0;
        repeat (2) tick();
        idle_inputs(); tick();
`ifdef FWD_STATS_EN
        check_val("fwd_count", 32'(fwd_count), 32'd3);
        check_val("stall_count", 32'(stall_count), 32'd2);
`else
        check_val("fwd_count", 32'(fwd_count), 32'd0);
        check_val("stall_count", 32'(stall_count), 32'd0);
`endif
        check_val("wd_after_stats", 32'(stall_timeout), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
